// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered O_CLK with period P and high time H,
// plus a double-buffered config that is applied only on period boundaries or while idle.
module clk_div_prog #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 42,
  parameter int DEFAULT_HIGH = 21
) (
  input  logic             I_CLK,
  input  logic             Rst,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] Div_Val,
  input  logic [WIDTH-1:0] High_Val,
  output logic             O_CLK,
  output logic             O_Tick,
  output logic             Load_Ack,
  output logic             Cfg_Err,
  output logic             Pend
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(DEFAULT_HIGH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic [WIDTH-1:0] phigh_q, phigh_d;
  logic             pend_q, pend_d;
  logic             o_clk_q, o_clk_d;
  logic             o_tick_q, o_tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             load_valid;
  logic             wrap;
  logic             apply;

  // High_Val < Div_Val is the unsigned form of High_Val <= Div_Val-1 once Div_Val >= 2.
  assign load_valid = (Div_Val >= TWO) && (High_Val != '0) && (High_Val < Div_Val);
  assign wrap       = (state_q == RUN) && En && (k_q == (div_q - ONE));
  assign apply      = pend_q && ((state_q == IDLE) || wrap);

  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (En)  state_d = RUN;
      RUN:     if (!En) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    high_d  = high_q;
    pdiv_d  = pdiv_q;
    phigh_d = phigh_q;
    pend_d  = pend_q;
    k_d     = '0;

    // The config already pending is applied first; a Load on the same edge queues behind it.
    if (apply) begin
      div_d  = pdiv_q;
      high_d = phigh_q;
      pend_d = 1'b0;
    end
    if (Load && load_valid) begin
      pdiv_d  = Div_Val;
      phigh_d = High_Val;
      pend_d  = 1'b1;
    end

    if ((state_d == RUN) && (state_q == RUN) && !wrap) begin
      k_d = k_q + ONE;
    end

    // Outputs are computed from the post-edge counter and config so they line up with k.
    o_clk_d  = (state_d == RUN) && (k_d < high_d);
    o_tick_d = (state_d == RUN) && (k_d == '0);
    ack_d    = apply;
    err_d    = Load && !load_valid;
  end

  always_ff @(posedge I_CLK or negedge Rst) begin
    if (!Rst) begin
      k_q      <= '0;
      div_q    <= DIV_RST;
      high_q   <= HIGH_RST;
      pdiv_q   <= '0;
      phigh_q  <= '0;
      pend_q   <= 1'b0;
      o_clk_q  <= 1'b0;
      o_tick_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      k_q      <= k_d;
      div_q    <= div_d;
      high_q   <= high_d;
      pdiv_q   <= pdiv_d;
      phigh_q  <= phigh_d;
      pend_q   <= pend_d;
      o_clk_q  <= o_clk_d;
      o_tick_q <= o_tick_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign O_CLK    = o_clk_q;
  assign O_Tick   = o_tick_q;
  assign Load_Ack = ack_q;
  assign Cfg_Err  = err_q;
  assign Pend     = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: period-level reference model compared every cycle,
// directed scenarios pinned with literal period lengths, then randomized traffic.
module tb_clk_div_prog;

  logic        I_CLK = 1'b0;
  logic        Rst = 1'b0;
  logic        En = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Div_Val = '0;
  logic [15:0] High_Val = '0;
  logic        O_CLK, O_Tick, Load_Ack, Cfg_Err, Pend;

  clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(42), .DEFAULT_HIGH(21)) dut (
    .I_CLK(I_CLK), .Rst(Rst), .En(En), .Load(Load),
    .Div_Val(Div_Val), .High_Val(High_Val),
    .O_CLK(O_CLK), .O_Tick(O_Tick), .Load_Ack(Load_Ack),
    .Cfg_Err(Cfg_Err), .Pend(Pend)
  );

  always #5 I_CLK = ~I_CLK;

  int vectors = 0;
  int fails = 0;

  // Reference model state: position in period, active/pending config.
  bit m_run = 0;
  int m_k = 0, m_P = 42, m_H = 21;
  bit m_pend = 0;
  int m_pP = 0, m_pH = 0;
  bit m_clk = 0, m_tick = 0, m_ack = 0, m_err = 0;
  int m_div, m_hi;
  bit m_valid, m_wrap, m_apply;

  // Measured periods of the DUT waveform (tick to tick).
  int per_len[$];
  int per_high[$];
  bit meas_on = 0;
  int cur_len = 0, cur_high = 0;
  int ack_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_k = 0; m_P = 42; m_H = 21;
    m_pend = 0; m_pP = 0; m_pH = 0;
    m_clk = 0; m_tick = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    m_div   = int'(Div_Val);
    m_hi    = int'(High_Val);
    m_valid = Load && (m_div >= 2) && (m_hi >= 1) && (m_hi <= m_div - 1);
    m_wrap  = m_run && En && (m_k == m_P - 1);
    m_apply = m_pend && (!m_run || m_wrap);
    m_ack   = m_apply;
    if (m_apply) begin
      m_P = m_pP; m_H = m_pH; m_pend = 0;
    end
    m_err = Load && !m_valid;
    if (m_valid) begin
      m_pend = 1; m_pP = m_div; m_pH = m_hi;
    end
    if (!En) begin
      m_run = 0; m_k = 0;
    end else if (!m_run) begin
      m_run = 1; m_k = 0;
    end else if (m_wrap) begin
      m_k = 0;
    end else begin
      m_k = m_k + 1;
    end
    m_clk  = m_run && (m_k < m_H);
    m_tick = m_run && (m_k == 0);
  endtask

  always @(posedge I_CLK or negedge Rst) begin
    if (!Rst) model_reset();
    else model_step();
  end

  task automatic compare_cycle();
    check("o_clk", O_CLK, m_clk);
    check("o_tick", O_Tick, m_tick);
    check("load_ack", Load_Ack, m_ack);
    check("cfg_err", Cfg_Err, m_err);
    check("pend", Pend, m_pend);
    ack_cnt += int'(Load_Ack);
    err_cnt += int'(Cfg_Err);
    if (!m_run) begin
      meas_on = 0;
    end else if (O_Tick) begin
      if (meas_on) begin
        per_len.push_back(cur_len);
        per_high.push_back(cur_high);
      end
      cur_len = 1; cur_high = int'(O_CLK); meas_on = 1;
    end else if (meas_on) begin
      cur_len++; cur_high += int'(O_CLK);
    end
  endtask

  always @(negedge I_CLK) compare_cycle();

  task automatic cyc();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_periods();
    per_len.delete();
    per_high.delete();
  endtask

  task automatic check_period(input string name, input int idx, input int len, input int high);
    if (per_len.size() <= idx) begin
      vectors++; fails++;
      $display("FAIL %s: period %0d not observed, expected len %0d high %0d", name, idx, len, high);
    end else begin
      check({name, "_len"}, per_len[idx], len);
      check({name, "_high"}, per_high[idx], high);
    end
  endtask

  task automatic check_last_period(input string name, input int len, input int high);
    if (per_len.size() == 0) begin
      vectors++; fails++;
      $display("FAIL %s: no period observed, expected len %0d high %0d", name, len, high);
    end else begin
      check({name, "_len"}, per_len[per_len.size()-1], len);
      check({name, "_high"}, per_high[per_high.size()-1], high);
    end
  endtask

  task automatic wait_k(input string name, input int target);
    int n = 0;
    while (m_k != target && n < 200) begin
      cyc();
      n++;
    end
    vectors++;
    if (m_k != target) begin
      fails++;
      $display("FAIL %s: timeout waiting for k, got %0d expected %0d", name, m_k, target);
    end
  endtask

  task automatic do_load(input int d, input int h);
    Load = 1'b1; Div_Val = 16'(d); High_Val = 16'(h);
    cyc();
    Load = 1'b0;
  endtask

  initial begin
    int acks0, errs0, n;

    // Reset state
    run(3);
    check("rst_o_clk", O_CLK, 0);
    check("rst_o_tick", O_Tick, 0);
    check("rst_pend", Pend, 0);
    check("rst_ack", Load_Ack, 0);
    check("rst_err", Cfg_Err, 0);
    Rst = 1'b1;
    run(2);

    // Default waveform: 21 high / 21 low
    clear_periods();
    En = 1'b1;
    cyc();
    check("start_tick", O_Tick, 1);
    check("start_clk", O_CLK, 1);
    run(90);
    check_period("dflt0", 0, 42, 21);
    check_period("dflt1", 1, 42, 21);

    // Mid-period load of (10,3) waits for the current period to finish
    wait_k("wait_k10", 10);
    clear_periods();
    acks0 = ack_cnt;
    do_load(10, 3);
    check("pend_after_load", Pend, 1);
    run(60);
    check("acks_10_3", ack_cnt - acks0, 1);
    check_period("cur42", 0, 42, 21);
    check_period("new10", 1, 10, 3);
    check_period("new10b", 2, 10, 3);

    // Rejected loads leave everything untouched
    errs0 = err_cnt;
    clear_periods();
    do_load(1, 0); run(2);
    do_load(5, 0); run(2);
    do_load(5, 5); run(2);
    do_load(0, 16'hFFFF); run(2);
    check("pend_after_bad", Pend, 0);
    run(30);
    check("bad_errs", err_cnt - errs0, 4);
    check_last_period("after_bad", 10, 3);

    // Drop En at k=5, restart
    wait_k("wait_k5", 5);
    En = 1'b0;
    cyc();
    check("en_drop_clk", O_CLK, 0);
    check("en_drop_tick", O_Tick, 0);
    run(2);
    En = 1'b1;
    cyc();
    check("restart_tick", O_Tick, 1);
    check("restart_clk", O_CLK, 1);

    // Latest pending load wins
    wait_k("wait_k2", 2);
    acks0 = ack_cnt;
    clear_periods();
    do_load(4, 2);
    do_load(6, 1);
    run(40);
    check("acks_latest", ack_cnt - acks0, 1);
    check_last_period("latest_wins", 6, 1);

    // Async reset in the high phase with a pending config
    do_load(9, 5);
    n = 0;
    while (m_P != 9 && n < 50) begin cyc(); n++; end
    check("apply_9_5", m_P, 9);
    wait_k("wait_k1", 1);
    do_load(8, 4);
    check("pre_rst_clk", O_CLK, 1);
    check("pre_rst_pend", Pend, 1);
    @(negedge I_CLK);
    #2;
    Rst = 1'b0;
    #1;
    check("async_rst_clk", O_CLK, 0);
    check("async_rst_pend", Pend, 0);
    check("async_rst_tick", O_Tick, 0);
    run(2);
    Rst = 1'b1;
    clear_periods();
    run(90);
    check_period("post_rst0", 0, 42, 21);
    check_period("post_rst1", 1, 42, 21);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      En       = ($urandom_range(0, 15) != 0);
      Load     = ($urandom_range(0, 7) == 0);
      Div_Val  = 16'($urandom_range(0, 12));
      High_Val = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 499) == 0) Rst = 1'b0;
      cyc();
      Rst = 1'b1;
    end
    Load = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 16: width of the period counter and of the config fields.
REQ-002 Parameter DEFAULT_DIV, default 42: period P after reset, in I_CLK cycles.
REQ-003 Parameter DEFAULT_HIGH, default 21: high time H after reset, in I_CLK cycles.
REQ-004 I_CLK  in  1  sole clock; all logic SHALL use its rising edge.
REQ-005 Rst  in  1  asynchronous, active-low reset.
REQ-006 En  in  1  run enable, level-sensitive.
REQ-007 Load  in  1  single-cycle request to capture Div_Val/High_Val.
REQ-008 Div_Val  in  WIDTH  requested period P.
REQ-009 High_Val  in  WIDTH  requested high time H.
REQ-010 O_CLK  out  1  divided clock, registered.
REQ-011 O_Tick  out  1  one-cycle pulse coincident with the first high cycle of each O_CLK period.
REQ-012 Load_Ack  out  1  one-cycle pulse when a pending config becomes active.
REQ-013 Cfg_Err  out  1  one-cycle pulse when a Load is rejected.
REQ-014 Pend  out  1  high while a validated config waits to be applied.

Function
REQ-015 The block SHALL have two states: IDLE and RUN.
REQ-016 It SHALL keep an internal counter k (WIDTH bits), active config (P,H), and a pending register plus a pending flag.
REQ-017 Outputs SHALL be registered with k, so that O_CLK == (k < H) and O_Tick == (k == 0) in every RUN cycle.
REQ-018 IDLE with En=1: on the next edge, k<=0, O_CLK<=1, O_Tick<=1, state<=RUN.
REQ-019 IDLE with En=0: k, O_CLK and O_Tick SHALL hold at 0.
REQ-020 RUN with En=1: k SHALL increment; when k==P-1, k SHALL wrap to 0, giving exactly H high and P-H low cycles per period.
REQ-021 RUN with En=0: on the next edge, state<=IDLE, k<=0, O_CLK<=0, O_Tick<=0; the current period is truncated.
REQ-022 A Load is valid iff Div_Val>=2 and 1<=High_Val<=Div_Val-1; comparisons SHALL be unsigned.
REQ-023 Valid Load: on the next edge the pending register SHALL take the values and Pend<=1.
REQ-024 A later valid Load SHALL overwrite an unapplied pending config (latest wins).
REQ-025 Invalid Load: Cfg_Err SHALL pulse on the next edge; pending and active configs SHALL stay unchanged.
REQ-026 Apply in RUN: on the wrap edge (k==P-1) with Pend=1, (P,H)<=pending, Pend<=0, and Load_Ack pulses; the new period starts with the new values.
REQ-027 Apply in IDLE: on the first edge with Pend=1, the pending config SHALL apply, with Load_Ack pulsing.
REQ-028 If IDLE->RUN start and apply share an edge, the new period SHALL use the new values.
REQ-029 Load coinciding with an apply edge: the previously pending config SHALL apply; the new Load SHALL become pending for the next boundary.
REQ-030 Load_Ack and Cfg_Err SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-031 Rst=0 SHALL immediately force: state=IDLE, k=0, O_CLK=0, O_Tick=0, Load_Ack=0, Cfg_Err=0, Pend=0, (P,H)=(DEFAULT_DIV,DEFAULT_HIGH).
REQ-032 Reset mid-period SHALL abort the period and discard any pending config.
REQ-033 After Rst deasserts, the first rising edge SHALL be treated as normal IDLE operation.

Verification
REQ-034 Defaults, En=1 after reset -> O_CLK 21 cycles high / 21 low, O_Tick once per 42 cycles.
REQ-035 In RUN, Load Div_Val=10, High_Val=3 mid-period -> Pend=1; current 42-cycle period completes; Load_Ack at the wrap; then 3 high / 7 low.
REQ-036 Load Div_Val=1 or High_Val=0 or High_Val=Div_Val -> Cfg_Err one cycle; Pend and waveform unchanged.
REQ-037 Drop En at k=5 -> O_CLK=0 next cycle; En high again -> new period starts at k=0 with O_Tick=1.
REQ-038 Two valid Loads (4,2) then (6,1) before a boundary -> only (6,1) applied; one Load_Ack.
REQ-039 Assert Rst asynchronously mid-high-phase with Pend=1 -> O_CLK=0 without a clock edge; Pend=0; defaults restored.
